// File: rtl/board_pkg.sv
// Shared definitions for the board display/scheduler blocks: cell codes,
// default VGA timing, and the write-scheduler FSM encoding.
package board_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHIP  = 2'd1,
      HIT   = 2'd2,
      MISS  = 2'd3
   } cell_t;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_TOTAL   = 800;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_TOTAL   = 525;

   typedef enum logic [1:0] {
      ST_DISPLAY  = 2'd0,
      ST_WIN_IDLE = 2'd1,
      ST_WRITE    = 2'd2
   } sched_state_t;

   // Half-open range test lo <= x < hi.
   function automatic logic in_range(input int x, input int lo, input int hi);
      return (x >= lo) && (x < hi);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, last-served pointer updated
// only when the grant is actually accepted.
module rr_arbiter2 (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic favour_b_reg;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = favour_b_reg ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // After serving A the pointer favours B, and vice versa.
   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset)
         favour_b_reg <= 1'b0;
      else if (accept && (grant != 2'b00))
         favour_b_reg <= grant[0];
   end

endmodule

// File: rtl/vga_board_write_scheduler.sv
// Board RAM port sharing between the VGA fetch path and two cell writers.
// Optional macro SCHED_HBLANK_EN also opens the write window in horizontal blanking.
module vga_board_write_scheduler
   import board_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_TOTAL   = VGA_V_TOTAL,
   parameter int H_TOTAL   = VGA_H_TOTAL,
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 2,
   parameter int MAX_WR    = 16
) (
   input  logic              clk_25MHz,
   input  logic              reset,
   input  logic [15:0]       h_count,
   input  logic [15:0]       v_count,
   input  logic [ADDR_W-1:0] pix_addr,
   input  logic              req_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_a,
   output logic              ack_b,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              in_window,
   output logic              frame_start
);

`ifdef SCHED_HBLANK_EN
   localparam logic HBLANK_EN = 1'b1;
`else
   localparam logic HBLANK_EN = 1'b0;
`endif

   localparam logic [7:0] MAX_WR_C = 8'(MAX_WR);

   sched_state_t      state_reg, state_next;
   logic              in_window_reg, frame_start_reg;
   logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
   logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
   logic              ram_we_reg, ram_we_next;
   logic              ack_a_reg, ack_a_next, ack_b_reg, ack_b_next;
   logic [7:0]        wr_cnt_reg;
   logic              win_cond, hblank_cond, frame_start_next;
   logic [1:0]        grant;
   logic              accept;

   // The last blank line (and the last two hblank pixels) stay closed so the
   // display owns the port again before it needs it.
   always_comb begin
      hblank_cond = (int'(v_count) < V_VISIBLE) &&
                    in_range(int'(h_count), H_VISIBLE, H_TOTAL - 2);
      win_cond    = in_range(int'(v_count), V_VISIBLE, V_TOTAL - 1) ||
                    (HBLANK_EN && hblank_cond);
   end

   assign frame_start_next = (h_count == 16'd0) && (v_count == 16'd0);

   rr_arbiter2 u_arb (
      .clk_25MHz (clk_25MHz),
      .reset     (reset),
      .req       ({req_b, req_a}),
      .accept    (accept),
      .grant     (grant)
   );

   always_comb begin
      state_next     = state_reg;
      ram_addr_next  = ram_addr_reg;
      ram_wdata_next = ram_wdata_reg;
      ram_we_next    = 1'b0;
      ack_a_next     = 1'b0;
      ack_b_next     = 1'b0;
      accept         = 1'b0;
      case (state_reg)
         ST_DISPLAY: begin
            ram_addr_next = pix_addr;
            if (in_window_reg)
               state_next = ST_WIN_IDLE;
         end
         ST_WIN_IDLE: begin
            if (!in_window_reg) begin
               state_next = ST_DISPLAY;
            end else if ((req_a || req_b) && (wr_cnt_reg < MAX_WR_C)) begin
               accept      = 1'b1;
               ram_we_next = 1'b1;
               state_next  = ST_WRITE;
               if (grant[1]) begin
                  ram_addr_next  = addr_b;
                  ram_wdata_next = wdata_b;
                  ack_b_next     = 1'b1;
               end else begin
                  ram_addr_next  = addr_a;
                  ram_wdata_next = wdata_a;
                  ack_a_next     = 1'b1;
               end
            end
         end
         ST_WRITE: state_next = ST_WIN_IDLE;
         default:  state_next = ST_DISPLAY;
      endcase
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         state_reg       <= ST_DISPLAY;
         in_window_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
         ram_addr_reg    <= '0;
         ram_wdata_reg   <= '0;
         ram_we_reg      <= 1'b0;
         ack_a_reg       <= 1'b0;
         ack_b_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         in_window_reg   <= win_cond;
         frame_start_reg <= frame_start_next;
         ram_addr_reg    <= ram_addr_next;
         ram_wdata_reg   <= ram_wdata_next;
         ram_we_reg      <= ram_we_next;
         ack_a_reg       <= ack_a_next;
         ack_b_reg       <= ack_b_next;
      end
   end

   // Frame-start clear wins over a same-cycle increment.
   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset)
         wr_cnt_reg <= 8'd0;
      else if (frame_start_reg)
         wr_cnt_reg <= 8'd0;
      else if ((state_reg == ST_WRITE) && (wr_cnt_reg != MAX_WR_C))
         wr_cnt_reg <= wr_cnt_reg + 8'd1;
   end

   assign ack_a       = ack_a_reg;
   assign ack_b       = ack_b_reg;
   assign ram_addr    = ram_addr_reg;
   assign ram_we      = ram_we_reg;
   assign ram_wdata   = ram_wdata_reg;
   assign in_window   = in_window_reg;
   assign frame_start = frame_start_reg;

endmodule
